// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports,
// data first, with a starvation counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t     r_state, w_next;
    logic       r_dm;
    logic [3:0] r_starve;
    logic       w_grant_dm, w_grant, w_done;
    assign w_grant_dm = dm_req & (~if_req | (r_starve < LIMIT));
    assign w_grant    = (r_state == IDLE) & (if_req | dm_req);
    assign w_done     = ((r_state == FETCH) | (r_state == DATA)) & mem_ack;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_grant_dm ? DATA : (if_req ? FETCH : IDLE)) :
                 (r_state == RESP) ? IDLE :
                 (mem_ack ? RESP : r_state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dm      <= 1'b0;
            r_starve  <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else if (w_grant) begin
            r_dm      <= w_grant_dm;
            r_starve  <= (w_grant_dm & if_req) ? r_starve + 4'(r_starve < LIMIT) : 4'd0;
            mem_req   <= 1'b1;
            mem_we    <= w_grant_dm & dm_we;
            mem_addr  <= w_grant_dm ? dm_addr : if_addr;
            mem_wdata <= w_grant_dm ? dm_wdata : '0;
        end else if (w_done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // mem_we still holds the granted direction at the ack edge
            if (r_dm) dm_rdata <= mem_we ? '0 : mem_rdata;
            else      if_rdata <= mem_rdata;
        end
    end
    assign if_rvalid = (r_state == RESP) & ~r_dm;
    assign dm_rvalid = (r_state == RESP) & r_dm;
    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = dm_req & ~dm_rvalid;
    assign busy      = r_state != IDLE;
endmodule
